btb_predictor: RTL and testbench

Branch target buffer with 2-bit saturating direction counters, placed in the IF stage. Each cycle it predicts the next fetch PC (`pc_BTB`) for the instruction at `IF_pc`. The branch hazard unit selects that prediction for control-flow instructions and overrides it on a misprediction. Resolved outcomes from EX train the table one clock later.

---
 rtl/btb_predictor_pkg.sv | 13 +
 rtl/sat_counter2.sv | 34 +++
 rtl/btb_predictor.sv | 98 +++++++++
 tb/tb_btb_predictor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and default table size.
package btb_predictor_pkg;

  localparam int BTB_ENTRY_BITS = 5;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_counter2
  import btb_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  input  logic force_strong,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (force_strong) begin
      ctr_next = CTR_ST;
    end else if (taken) begin
      unique case (ctr)
        CTR_SNT: ctr_next = CTR_WNT;
        CTR_WNT: ctr_next = CTR_WT;
        CTR_WT:  ctr_next = CTR_ST;
        CTR_ST:  ctr_next = CTR_ST;
        default: ctr_next = ctr;
      endcase
    end else begin
      unique case (ctr)
        CTR_SNT: ctr_next = CTR_SNT;
        CTR_WNT: ctr_next = CTR_SNT;
        CTR_WT:  ctr_next = CTR_WNT;
        CTR_ST:  ctr_next = CTR_WT;
        default: ctr_next = ctr;
      endcase
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// IF-stage branch target buffer with 2-bit direction counters.
// Optional gshare indexing is enabled by defining BTB_GSHARE_EN.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = BTB_ENTRY_BITS,
  parameter int TAG_BITS   = 30 - ENTRY_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           IF_pc,
  output logic [31:0]           pc_BTB,
  output logic [ENTRY_BITS-1:0] IF_pred_idx,
  input  logic                  update_valid,
  input  logic [ENTRY_BITS-1:0] update_idx,
  input  logic [31:0]           update_pc,
  input  logic                  update_taken,
  input  logic                  update_is_jump,
  input  logic [31:0]           update_target
);

  localparam int unsigned ENTRIES = 1 << ENTRY_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  ctr_e                ctr_q    [ENTRIES];

  logic [ENTRY_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  lookup_hit;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  ctr_e                  ctr_next;

  // Index and alignment bits of update_pc are not needed: update_idx carries the index.
  logic unused_upd_bits;
  assign unused_upd_bits = ^update_pc[ENTRY_BITS+1:0];

`ifdef BTB_GSHARE_EN
  logic [ENTRY_BITS-1:0] ghr_q;
  assign lookup_idx = IF_pc[ENTRY_BITS+1:2] ^ ghr_q;
`else
  assign lookup_idx = IF_pc[ENTRY_BITS+1:2];
`endif

  assign lookup_tag  = IF_pc[31:ENTRY_BITS+2];
  assign IF_pred_idx = lookup_idx;

  // Reads come straight from the registers, so a same-cycle update is not seen (read-old).
  always_comb begin
    lookup_hit = !reset && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag)
                 && ctr_q[lookup_idx][1];
    pc_BTB     = lookup_hit ? target_q[lookup_idx] : IF_pc + 32'd4;
  end

  assign upd_tag = update_pc[31:ENTRY_BITS+2];
  assign upd_hit = valid_q[update_idx] && (tag_q[update_idx] == upd_tag);

  sat_counter2 u_ctr (
    .ctr          (ctr_q[update_idx]),
    .taken        (update_taken),
    .force_strong (update_is_jump),
    .ctr_next     (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (update_valid) begin
      if (upd_hit) begin
        ctr_q[update_idx] <= ctr_next;
        if (update_taken || update_is_jump) begin
          target_q[update_idx] <= update_target;
        end
      end else if (update_taken || update_is_jump) begin
        valid_q[update_idx]  <= 1'b1;
        tag_q[update_idx]    <= upd_tag;
        target_q[update_idx] <= update_target;
        ctr_q[update_idx]    <= update_is_jump ? CTR_ST : CTR_WT;
      end
    end
  end

`ifdef BTB_GSHARE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (update_valid && !update_is_jump) begin
      ghr_q <= {ghr_q[ENTRY_BITS-2:0], update_taken};
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed scoreboard bench for btb_predictor in its default (non-gshare) build.
module tb_btb_predictor;

  localparam int EB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   IF_pc;
  logic [31:0]   pc_BTB;
  logic [EB-1:0] IF_pred_idx;
  logic          update_valid;
  logic [EB-1:0] update_idx;
  logic [31:0]   update_pc;
  logic          update_taken;
  logic          update_is_jump;
  logic [31:0]   update_target;

  typedef struct {
    string         tag;
    logic [31:0]   pc;
    logic [EB-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  btb_predictor #(.ENTRY_BITS(EB)) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_pc          (IF_pc),
    .pc_BTB         (pc_BTB),
    .IF_pred_idx    (IF_pred_idx),
    .update_valid   (update_valid),
    .update_idx     (update_idx),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_is_jump (update_is_jump),
    .update_target  (update_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

  // Drive one cycle of stimulus, push expected lookup result, compare at negedge.
  task automatic step(input string tag, input logic rst, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic tk,
                      input logic jmp, input logic [31:0] tgt, input logic [31:0] exp_pc);
    exp_t e;
    logic [31:0] pcv;
    @(posedge clk);
    #1;
    reset          = rst;
    IF_pc          = pc;
    update_valid   = uv;
    update_pc      = upc;
    update_idx     = upc[EB+1:2];
    update_taken   = tk;
    update_is_jump = jmp;
    update_target  = tgt;
    pcv            = pc;
    exp_q.push_back('{tag: tag, pc: exp_pc, idx: pcv[EB+1:2]});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    assert (pc_BTB === e.pc) else begin
      fails++;
      $error("FAIL %s pc_BTB observed=%h expected=%h", e.tag, pc_BTB, e.pc);
    end
    checks++;
    assert (IF_pred_idx === e.idx) else begin
      fails++;
      $error("FAIL %s_idx IF_pred_idx observed=%h expected=%h", e.tag, IF_pred_idx, e.idx);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc);
    step(tag, 1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, exp_pc);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] upc,
                     input logic tk, input logic jmp, input logic [31:0] tgt,
                     input logic [31:0] exp_pc);
    step(tag, 1'b0, pc, 1'b1, upc, tk, jmp, tgt, exp_pc);
  endtask

  initial begin
    reset = 1'b1; IF_pc = '0; update_valid = 1'b0; update_idx = '0; update_pc = '0;
    update_taken = 1'b0; update_is_jump = 1'b0; update_target = '0;

    // Reset with an update presented: update dropped, lookup falls through.
    step("rst_lookup", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h104);
    step("rst_drop_upd", 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 32'h900, 32'h304);
    look("rst_dropped", 32'h300, 32'h304);

    look("cold", 32'h100, 32'h104);
    upd("alloc_readold", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    look("alloc_hit", 32'h100, 32'h80);

    // Hysteresis 10 -> 01 -> 10, then saturation at 11.
    upd("nt1", 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 32'h80);
    look("ctr_wnt", 32'h100, 32'h104);
    upd("t1", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    look("ctr_wt", 32'h100, 32'h80);
    for (int i = 0; i < 4; i++) upd("t_sat", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    upd("nt_from_st", 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 32'h80);
    look("ctr_wt_after_sat", 32'h100, 32'h80);
    upd("nt2", 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 32'h80);
    look("ctr_wnt2", 32'h100, 32'h104);
    for (int i = 0; i < 3; i++) upd("nt_floor", 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
    upd("t_from_snt", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    look("ctr_wnt_from_snt", 32'h100, 32'h104);
    upd("t_retrain", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    look("retrained", 32'h100, 32'h80);

    // Alias on index 0: different tag misses, then a jump evicts.
    look("alias_miss", 32'h180, 32'h184);
    upd("alias_jump", 32'h180, 32'h180, 1'b1, 1'b1, 32'h40, 32'h184);
    look("alias_hit", 32'h180, 32'h40);
    look("evicted", 32'h100, 32'h104);

    // Not-taken miss allocates nothing.
    upd("nt_miss", 32'h2C0, 32'h2C0, 1'b0, 1'b0, 32'h700, 32'h2C4);
    look("nt_miss_none", 32'h2C0, 32'h2C4);

    // Same-cycle collision on allocation.
    upd("collide", 32'h200, 32'h200, 1'b1, 1'b0, 32'h1000, 32'h204);
    look("collide_next", 32'h200, 32'h1000);
    look("collide_evict", 32'h180, 32'h184);

    // Wrap and misaligned PCs.
    look("wrap", 32'hFFFF_FFFC, 32'h0000_0000);
    look("misaligned_miss", 32'h103, 32'h107);
    look("misaligned_hit", 32'h202, 32'h1000);

    // Jump on an existing weak branch entry forces strong-taken and new target.
    upd("br_alloc", 32'h2C0, 32'h2C0, 1'b1, 1'b0, 32'h500, 32'h2C4);
    upd("br_nt", 32'h2C0, 32'h2C0, 1'b0, 1'b0, 32'h0, 32'h500);
    look("br_wnt", 32'h2C0, 32'h2C4);
    upd("jmp_on_hit", 32'h2C0, 32'h2C0, 1'b1, 1'b1, 32'h600, 32'h2C4);
    look("jmp_strong", 32'h2C0, 32'h600);
    upd("nt_after_jmp", 32'h2C0, 32'h2C0, 1'b0, 1'b0, 32'h0, 32'h600);
    look("nt_keeps_tgt", 32'h2C0, 32'h600);

    // Reset mid-run with an update: all training discarded.
    step("midrst", 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h204);
    look("post_rst_200", 32'h200, 32'h204);
    look("post_rst_2c0", 32'h2C0, 32'h2C4);
    look("post_rst_100", 32'h100, 32'h104);

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
